// File: rtl/bridge_pkg.sv
// Shared definitions for the system bridge: FSM states and device window map.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam int unsigned MAX_DEV       = 6;
  localparam int unsigned WIN_BYTES_DEF = 12;

  localparam logic [31:0] DEV_BASE [MAX_DEV] = '{
    32'h0000_7F00, 32'h0000_7F10, 32'h0000_7F20,
    32'h0000_7F30, 32'h0000_7F40, 32'h0000_7F50
  };

endpackage

// File: rtl/bridge_addr_dec.sv
// Combinational window decoder: one-hot hit (lowest index wins), miss,
// misalignment and in-window offset.
module bridge_addr_dec
  import bridge_pkg::*;
#(
  parameter int unsigned NUM_DEV   = 3,
  parameter int unsigned WIN_BYTES = WIN_BYTES_DEF,
  parameter int unsigned OFF_W     = 4
) (
  input  logic [31:0]        addr_i,
  output logic [NUM_DEV-1:0] hit_o,
  output logic               miss_o,
  output logic               misalign_o,
  output logic [OFF_W-1:0]   offset_o
);

  logic [NUM_DEV:0]            seen;
  logic [NUM_DEV:0][OFF_W-1:0] off_acc;

  assign seen[0]    = 1'b0;
  assign off_acc[0] = '0;

  for (genvar g = 0; g < NUM_DEV; g++) begin : g_win
    localparam logic [31:0] LO = DEV_BASE[g];
    localparam logic [31:0] HI = DEV_BASE[g] + 32'(WIN_BYTES) - 32'd1;

    logic             in_win;
    logic [OFF_W-1:0] off;

    assign in_win = (addr_i >= LO) && (addr_i <= HI);
    // Low bits of a difference depend only on the low bits of the operands.
    assign off          = addr_i[OFF_W-1:0] - LO[OFF_W-1:0];
    assign hit_o[g]     = in_win & ~seen[g];
    assign seen[g+1]    = seen[g] | in_win;
    assign off_acc[g+1] = off_acc[g] | (hit_o[g] ? off : '0);
  end

  assign miss_o     = ~seen[NUM_DEV];
  assign misalign_o = |addr_i[1:0];
  assign offset_o   = off_acc[NUM_DEV];

endmodule

// File: rtl/sys_bridge_n.sv
// CPU data-port to NUM_DEV peripheral bridge with registered handshake,
// wait states, timeout, decode errors and registered interrupt aggregation.
module sys_bridge_n
  import bridge_pkg::*;
#(
  parameter int unsigned NUM_DEV   = 3,
  parameter int unsigned WIN_BYTES = WIN_BYTES_DEF,
  parameter int unsigned OFF_W     = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_byteen,
  output logic                    cpu_ready,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_err,
  output logic [NUM_DEV-1:0]      dev_sel,
  output logic                    dev_we,
  output logic [OFF_W-1:0]        dev_addr,
  output logic [31:0]             dev_wdata,
  output logic [3:0]              dev_byteen,
  input  logic [NUM_DEV-1:0]      dev_ack,
  input  logic [NUM_DEV*32-1:0]   dev_rdata,
  input  logic [NUM_DEV-1:0]      dev_irq,
  output logic [5:0]              hw_int
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [NUM_DEV-1:0]   sel_q, sel_d;
  logic                 we_q, we_d;
  logic [OFF_W-1:0]     addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           byteen_q, byteen_d;
  logic [5:0]           irq_q, irq_d;

  logic [NUM_DEV-1:0]   hit;
  logic                 miss, misalign;
  logic [OFF_W-1:0]     offset;
  logic                 ack_sel;
  logic [NUM_DEV:0][31:0] rd_acc;

  bridge_addr_dec #(
    .NUM_DEV   (NUM_DEV),
    .WIN_BYTES (WIN_BYTES),
    .OFF_W     (OFF_W)
  ) u_dec (
    .addr_i     (cpu_addr),
    .hit_o      (hit),
    .miss_o     (miss),
    .misalign_o (misalign),
    .offset_o   (offset)
  );

  assign rd_acc[0] = '0;
  for (genvar g = 0; g < NUM_DEV; g++) begin : g_rd
    assign rd_acc[g+1] = rd_acc[g] | (sel_q[g] ? dev_rdata[32*g +: 32] : '0);
  end

  // Acks from devices other than the selected one are ignored.
  assign ack_sel = |(dev_ack & sel_q);

  always_comb begin
    irq_d              = '0;
    irq_d[NUM_DEV-1:0] = dev_irq;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    byteen_d = byteen_q;

    unique case (state_q)
      IDLE: begin
        err_d   = 1'b0;
        rdata_d = '0;
        cnt_d   = '0;
        if (cpu_req) begin
          if (miss || misalign) begin
            state_d = DONE;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = ACCESS;
            sel_d    = hit;
            we_d     = cpu_we;
            addr_d   = offset;
            wdata_d  = cpu_wdata;
            byteen_d = cpu_byteen;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ack_sel) begin
          state_d = DONE;
          ready_d = 1'b1;
          sel_d   = '0;
          we_d    = 1'b0;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : rd_acc[NUM_DEV];
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          state_d = DONE;
          ready_d = 1'b1;
          sel_d   = '0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
      irq_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      byteen_q <= byteen_d;
      irq_q    <= irq_d;
    end
  end

  assign cpu_ready  = ready_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_err    = err_q;
  assign dev_sel    = sel_q;
  assign dev_we     = we_q;
  assign dev_addr   = addr_q;
  assign dev_wdata  = wdata_q;
  assign dev_byteen = byteen_q;
  assign hw_int     = irq_q;

endmodule

// File: tb/tb_sys_bridge_n.sv
// Scoreboard bench for sys_bridge_n with three modelled devices.
module tb_sys_bridge_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [2:0]  dev_sel;
  logic        dev_we;
  logic [3:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic [3:0]  dev_byteen;
  logic [2:0]  dev_ack;
  logic [95:0] dev_rdata;
  logic [2:0]  dev_irq;
  logic [5:0]  hw_int;

  sys_bridge_n #(
    .NUM_DEV   (3),
    .WIN_BYTES (12),
    .OFF_W     (4),
    .TIMEOUT   (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_byteen (cpu_byteen),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .dev_sel    (dev_sel),
    .dev_we     (dev_we),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_byteen (dev_byteen),
    .dev_ack    (dev_ack),
    .dev_rdata  (dev_rdata),
    .dev_irq    (dev_irq),
    .hw_int     (hw_int)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb_q[$];
  int    vectors    = 0;
  int    miscompares = 0;
  logic [5:0] exp_hw = '0;

  // Device model: device i acks in its lat[i]-th selected cycle (0 = never).
  int         lat [3];
  int         sel_cnt [3];
  logic [2:0] ack_r = '0;
  logic [2:0] spur  = '0;

  assign dev_ack   = ack_r | spur;
  assign dev_rdata = {32'h2222_0002, 32'h1111_0001, 32'hDEAD_BEEF};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dev_sel[i]) sel_cnt[i]++;
      else            sel_cnt[i] = 0;
      ack_r[i] = dev_sel[i] && (lat[i] != 0) && (sel_cnt[i] == lat[i]);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cpu_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected cpu_ready", 32'(cpu_ready), 32'd0);
      end else begin
        resp_t r;
        r = sb_q.pop_front();
        check("cpu_rdata", cpu_rdata, r.rdata);
        check("cpu_err", 32'(cpu_err), 32'(r.err));
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [2:0] exp_sel, input logic [3:0] exp_off, input int exp_cyc,
                        input bit chk_dev, input string name);
    int cyc;
    bit done;
    cpu_req    = 1'b1;
    cpu_we     = we;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    cpu_byteen = be;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    cyc  = 0;
    done = 0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (cpu_ready) begin
        done = 1;
      end else if (chk_dev) begin
        check({name, " dev_sel"}, 32'(dev_sel), 32'(exp_sel));
        check({name, " dev_we"}, 32'(dev_we), 32'(we));
        check({name, " dev_addr"}, 32'(dev_addr), 32'(exp_off));
        check({name, " dev_byteen"}, 32'(dev_byteen), 32'(be));
        if (we) check({name, " dev_wdata"}, dev_wdata, wdata);
      end
      check({name, " hw_int"}, 32'(hw_int), 32'(exp_hw));
    end
    if (!done) check({name, " ready timeout"}, 32'd0, 32'd1);
    check({name, " latency"}, 32'(cyc), 32'(exp_cyc));
    check({name, " sel dropped"}, 32'(dev_sel), 32'd0);
    check({name, " we dropped"}, 32'(dev_we), 32'd0);
    cpu_req = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    check({nm, " cpu_ready"}, 32'(cpu_ready), 32'd0);
    check({nm, " cpu_err"}, 32'(cpu_err), 32'd0);
    check({nm, " cpu_rdata"}, cpu_rdata, 32'd0);
    check({nm, " dev_sel"}, 32'(dev_sel), 32'd0);
    check({nm, " dev_we"}, 32'(dev_we), 32'd0);
    check({nm, " dev_addr"}, 32'(dev_addr), 32'd0);
    check({nm, " dev_wdata"}, dev_wdata, 32'd0);
    check({nm, " dev_byteen"}, 32'(dev_byteen), 32'd0);
    check({nm, " hw_int"}, 32'(hw_int), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    cpu_byteen = '0;
    dev_irq    = '0;
    lat        = '{1, 3, 0};
    sel_cnt    = '{0, 0, 0};
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;

    @(negedge clk);
    dev_irq = 3'b101;
    check("hw_int before edge", 32'(hw_int), 32'd0);
    @(negedge clk);
    exp_hw = 6'b000101;
    check("hw_int registered", 32'(hw_int), 32'(exp_hw));

    // Read, immediate ack
    @(negedge clk);
    access(1'b0, 32'h7F04, '0, 4'hF, 32'hDEAD_BEEF, 1'b0, 3'b001, 4'd4, 2, 1, "rd 7F04");

    // Write with wait states; stray acks on unselected devices must be ignored
    @(negedge clk);
    spur = 3'b101;
    access(1'b1, 32'h7F18, 32'h1234_5678, 4'b0011, 32'd0, 1'b0, 3'b010, 4'd8, 4, 1, "wr 7F18");
    spur = 3'b000;
    repeat (3) begin
      @(negedge clk);
      check("no extra dev_we", 32'(dev_we), 32'd0);
    end

    // Decode errors
    @(negedge clk);
    access(1'b0, 32'h7F30, '0, 4'hF, 32'd0, 1'b1, 3'b000, 4'd0, 1, 1, "unmapped 7F30");
    @(negedge clk);
    access(1'b0, 32'h7F02, '0, 4'hF, 32'd0, 1'b1, 3'b000, 4'd0, 1, 1, "misaligned 7F02");
    @(negedge clk);
    access(1'b0, 32'h7F0C, '0, 4'hF, 32'd0, 1'b1, 3'b000, 4'd0, 1, 1, "gap 7F0C");
    @(negedge clk);
    access(1'b1, 32'h7F1C, 32'hAAAA_5555, 4'hF, 32'd0, 1'b1, 3'b000, 4'd0, 1, 1, "gap 7F1C");

    // Last word of window 0, and zero-byteen write still completes
    lat[0] = 1;
    lat[1] = 1;
    @(negedge clk);
    access(1'b0, 32'h7F08, '0, 4'hF, 32'hDEAD_BEEF, 1'b0, 3'b001, 4'd8, 2, 1, "rd 7F08");
    @(negedge clk);
    access(1'b1, 32'h7F10, 32'hCAFE_F00D, 4'b0000, 32'd0, 1'b0, 3'b010, 4'd0, 2, 1, "wr be0 7F10");

    // Timeout on device 2
    @(negedge clk);
    access(1'b0, 32'h7F20, '0, 4'hF, 32'd0, 1'b1, 3'b100, 4'd0, 16, 1, "timeout 7F20");

    // Back-to-back: second request issued during the DONE cycle
    @(negedge clk);
    access(1'b0, 32'h7F14, '0, 4'hF, 32'h1111_0001, 1'b0, 3'b010, 4'd4, 2, 1, "rd 7F14");
    access(1'b0, 32'h7F08, '0, 4'hF, 32'hDEAD_BEEF, 1'b0, 3'b001, 4'd8, 3, 0, "b2b 7F08");

    // Reset in the middle of an access
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h7F20;
    repeat (4) @(negedge clk);
    check("mid-access dev_sel", 32'(dev_sel), 32'b100);
    reset   = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check_zero("mid-access reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post-reset dev_sel", 32'(dev_sel), 32'd0);
    check("post-reset hw_int", 32'(hw_int), 32'(exp_hw));
    access(1'b0, 32'h7F00, '0, 4'hF, 32'hDEAD_BEEF, 1'b0, 3'b001, 4'd0, 2, 1, "rd 7F00");

    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sys_bridge_n.md
Name: sys_bridge_n

Overview:
- Parametrised system bridge between the CPU data-memory port and NUM_DEV memory-mapped peripherals (timers, UART and similar).
- Next generation of the two-timer combinational bridge. It adds:
  - N address windows;
  - byte enables;
  - a registered request/ready handshake with device wait states;
  - a timeout;
  - unmapped and misaligned error reporting;
  - registered interrupt aggregation into HWInt.
- Sits between the CPU MEM stage (the stall logic consumes cpu_ready) and the peripheral blocks.

Parameters:
- NUM_DEV, 3: number of device windows (1..6).
- WIN_BYTES, 12: size of each window in bytes. Window i is [DEV_BASE[i], DEV_BASE[i]+WIN_BYTES-1].
- OFF_W, 4: width of the device-side offset address.
- TIMEOUT, 15: number of ACCESS cycles without an ack before the access aborts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  access request. The CPU holds cpu_req and all cpu_* inputs stable until cpu_ready is high.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_byteen  in  4  write byte enables.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data, valid while cpu_ready=1.
- cpu_err  out  1  access error, valid while cpu_ready=1.
- dev_sel  out  NUM_DEV  one-hot device select.
- dev_we  out  1  device write strobe.
- dev_addr  out  OFF_W  offset inside the selected window.
- dev_wdata  out  32  write data to the device.
- dev_byteen  out  4  byte enables to the device.
- dev_ack  in  NUM_DEV  per-device completion.
- dev_rdata  in  NUM_DEV*32  flattened device read data; device i occupies bits [32i+31:32i].
- dev_irq  in  NUM_DEV  device interrupt lines.
- hw_int  out  6  registered interrupt vector to CP0.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE and the timeout counter is 0;
  - cpu_ready=0, cpu_err=0, cpu_rdata=0;
  - dev_sel=0, dev_we=0, dev_addr=0, dev_wdata=0, dev_byteen=0, hw_int=0.
  - A reset mid-access aborts the access: no ready pulse is produced and no further device strobe is issued.
- All outputs are registered.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - cpu_req is sampled only in IDLE.
  - On cpu_req=1, latch we, addr, wdata and byteen, and decode the address.
  - Hit on window i with addr[1:0]==0: next state ACCESS; dev_sel[i]=1; dev_we=we; dev_addr=(addr-DEV_BASE[i])[OFF_W-1:0]; dev_wdata and dev_byteen driven from the latch.
  - Miss or misaligned address: next state DONE with cpu_err=1 and cpu_rdata=0. No device is selected.
  - Overlapping windows: the lowest index wins.
- ACCESS:
  - dev_sel, dev_we and the other dev_* outputs are held. The counter increments each cycle.
  - dev_ack[i]=1 for the selected i: drop dev_sel and dev_we, go to DONE. cpu_rdata=dev_rdata[i] on a read, 0 on a write. cpu_err=0.
  - Counter reaches TIMEOUT with no ack: drop dev_sel, go to DONE with cpu_err=1 and cpu_rdata=0.
  - dev_ack bits of non-selected devices are ignored.
- DONE:
  - cpu_ready=1 for exactly this cycle. Then go to IDLE and clear the counter.
  - The CPU advances at the edge that closes DONE. cpu_req in the following IDLE cycle is therefore a new access, so back-to-back accesses are legal.
- Latency: with a device that acks immediately, req sampled in cycle 0 gives ACCESS in cycle 1 and cpu_ready=1 in cycle 2. An error on decode gives cpu_ready=1 in cycle 1.
- A write with byteen=4'b0000 still performs a normal access; the device treats it as a no-op.
- Interrupts: hw_int[i] is dev_irq[i] registered with one cycle of latency, for i<NUM_DEV. hw_int[5:NUM_DEV]=0. This path is independent of the FSM state.

Decomposition:
- Shared package bridge_pkg holds:
  - the state enum {IDLE, ACCESS, DONE};
  - the DEV_BASE array: 32'h0000_7F00, 32'h0000_7F10, 32'h0000_7F20, then +0x10 per device;
  - the default WIN_BYTES.
- One combinational sub-module, bridge_addr_dec: takes addr and returns the one-hot hit vector (lowest index wins), the miss flag, the misaligned flag and the offset.

Test Plan:
- Read at 0x7F04, device 0 acks in its first ACCESS cycle with rdata 0xDEADBEEF → dev_sel=3'b001 and dev_addr=4 in cycle 1; cpu_ready=1, cpu_rdata=0xDEADBEEF, cpu_err=0 in cycle 2.
- Write 0x12345678 with byteen 4'b0011 to 0x7F18, device 1 acks after 3 cycles → dev_we=1, dev_addr=8, dev_byteen=4'b0011 held for 3 cycles; cpu_ready occurs exactly once and no further dev_we pulses follow.
- Read at 0x7F30 (unmapped) and at 0x7F02 (misaligned) → dev_sel stays 0; cpu_ready=1, cpu_err=1, cpu_rdata=0 in cycle 1.
- Device 2 never acks on a read at 0x7F20 → dev_sel held for 15 cycles, then cpu_ready=1 with cpu_err=1 and cpu_rdata=0; the FSM returns to IDLE.
- reset=0 asserted during ACCESS, then released → all outputs 0 and no cpu_ready pulse; a new read at 0x7F00 afterwards completes normally.
- dev_irq=3'b101 → hw_int=6'b000101 one cycle later; the value does not change during any bus access.
